// File: rtl/out_port_sched.sv
// out_port_sched: round-robin owner of the shared output register, with a per-owner burst limit
// and a forced idle spacing between output pulses.
module out_port_sched #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_MAX = 2,
   parameter int MIN_GAP   = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      dataoutvx2,
   output logic [DATA_W-1:0]         dataoutx2,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(BURST_MAX + 1);
   localparam int GW = $clog2(MIN_GAP + 2);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   logic [1:0]        state;
   logic [IW-1:0]     rr_ptr, owner, win, idx, sel;
   logic [CW-1:0]     burst_cnt;
   logic [GW-1:0]     gap_cnt;
   logic              go, can_idle, can_burst;
   logic [DATA_W-1:0] beat;

   // descending scan so the lowest offset from rr_ptr wins
   always_comb begin
      win = rr_ptr;
      idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = IW'((int'(rr_ptr) + k) % N_REQ);
         if (req_valid[idx]) win = idx;
      end
   end

   always_comb begin
      can_idle  = state == IDLE && enable && |req_valid;
      can_burst = state == BURST && enable && req_valid[owner] && burst_cnt < CW'(BURST_MAX);
      sel       = state == IDLE ? win : owner;
      go        = !reset && (can_idle || can_burst);
      req_ready = go ? N_REQ'(1) << sel : '0;
      beat      = req_data[int'(sel)*DATA_W +: DATA_W];
   end

   assign busy = state != IDLE;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         burst_cnt  <= '0;
         gap_cnt    <= '0;
         dataoutvx2 <= 1'b0;
         dataoutx2  <= '0;
         grant_id   <= '0;
      end else begin
         dataoutvx2 <= go;
         if (go) begin
            dataoutx2 <= beat;
            owner     <= sel;
            grant_id  <= sel;
            burst_cnt <= state == IDLE ? CW'(1) : burst_cnt + 1'b1;
            gap_cnt   <= GW'(MIN_GAP);
            state     <= MIN_GAP > 0 ? GAP : BURST;
         end else if (state == BURST) begin
            if (!req_valid[owner] || burst_cnt >= CW'(BURST_MAX)) begin
               rr_ptr <= owner == IW'(N_REQ - 1) ? '0 : owner + 1'b1;
               state  <= IDLE;
            end
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == GW'(1)) state <= BURST;
         end else if (state != IDLE) begin
            state <= IDLE;
         end
      end
   end
endmodule
